// File: rtl/mv_result_streamer.sv
// Streams one matrix-vector result frame from shared BRAM onto a valid/ready port.
// Optional feature: define MV_RESULT_CHECKSUM_EN to add the frame XOR checksum output.
//
// state | meaning
// IDLE  | waiting for trig from the PE controller
// READ  | issuing BRAM reads while rd_idx < VECTOR_SIZE
// DRAIN | all reads issued, emptying the prefetch buffer
module mv_result_streamer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned VECTOR_SIZE = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int unsigned CNT_WIDTH   = 7
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  trig,
   output logic                  busy,
   output logic                  frame_done,
   output logic [31:0]           BRAM_ADDR,
   output logic                  BRAM_EN,
   output logic [3:0]            BRAM_WE,
   input  logic [DATA_WIDTH-1:0] BRAM_RDDATA,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast
`ifdef MV_RESULT_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTOR_SIZE - 1);

   state_t                state_q;
   state_t                state_d;
   logic [CNT_WIDTH-1:0]  rd_idx_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [1:0]            fifo_last_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic                  frame_done_q;

   logic                  trig_acc;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic                  hs_last;
   logic [1:0]            committed;

   // Popping entry counts as freed, which keeps one read per cycle under full ready.
   always_comb begin
      m_tvalid  = (count_q != 2'd0);
      pop       = m_tvalid && m_tready;
      push      = inflight_q;
      committed = count_q - {1'b0, pop} + {1'b0, inflight_q};
      issue     = (state_q == ST_READ) && (committed < 2'd2);
      trig_acc  = (state_q == ST_IDLE) && trig;
      m_tdata   = fifo_data_q[rd_ptr_q];
      m_tlast   = m_tvalid && fifo_last_q[rd_ptr_q];
      hs_last   = pop && m_tlast;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trig) state_d = ST_READ;
         end
         ST_READ: begin
            if (issue && (rd_idx_q == LAST_IDX)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (hs_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_idx_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue && (rd_idx_q == LAST_IDX);
         if (trig_acc)   rd_idx_q <= '0;
         else if (issue) rd_idx_q <= rd_idx_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_last_q    <= 2'b00;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q] <= BRAM_RDDATA;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) frame_done_q <= 1'b0;
      else          frame_done_q <= hs_last;
   end

`ifdef MV_RESULT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)      checksum_q <= '0;
      else if (trig_acc) checksum_q <= '0;
      else if (pop)      checksum_q <= checksum_q ^ m_tdata;
   end

   assign checksum = checksum_q;
`endif

   // Address is forced to zero when idle so reset and idle both present 0.
   assign BRAM_EN    = issue;
   assign BRAM_ADDR  = issue ? (BASE_ADDR + (32'(rd_idx_q) << 2)) : 32'h0;
   assign BRAM_WE    = 4'h0;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mv_result_streamer.sv
// Randomized bench for mv_result_streamer: BRAM model, frame-level reference model,
// per-cycle compare process and a few literal checks from the test plan.
module tb_mv_result_streamer;
   localparam int          DW   = 32;
   localparam int          N    = 64;
   localparam logic [31:0] BASE = 32'h0;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          trig = 1'b0;
   logic          m_tready = 1'b0;
   logic          busy, frame_done, BRAM_EN, m_tvalid, m_tlast;
   logic [31:0]   BRAM_ADDR;
   logic [3:0]    BRAM_WE;
   logic [DW-1:0] BRAM_RDDATA = '0;
   logic [DW-1:0] m_tdata;
`ifdef MV_RESULT_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int total = 0;
   int bad = 0;

   logic [DW-1:0] mem [N];

   always #5 aclk = ~aclk;

   mv_result_streamer #(
      .DATA_WIDTH (DW),
      .VECTOR_SIZE(N),
      .BASE_ADDR  (BASE),
      .CNT_WIDTH  (7)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .trig       (trig),
      .busy       (busy),
      .frame_done (frame_done),
      .BRAM_ADDR  (BRAM_ADDR),
      .BRAM_EN    (BRAM_EN),
      .BRAM_WE    (BRAM_WE),
      .BRAM_RDDATA(BRAM_RDDATA),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast)
`ifdef MV_RESULT_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   // BRAM: one-cycle read latency
   int unsigned bram_ix;
   always @(posedge aclk) begin
      if (BRAM_EN) begin
         bram_ix = (BRAM_ADDR - BASE) >> 2;
         BRAM_RDDATA <= (bram_ix < N) ? mem[bram_ix] : 32'hBAD0_BAD0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model state: a frame is the ordered list mem[0..N-1]
   logic          m_active = 1'b0;
   logic          m_done_exp = 1'b0;
   int            m_beat = 0;
   int            m_reads = 0;
   int            m_hs = 0;
   logic [DW-1:0] m_xor = '0;
   logic          prev_valid = 1'b0;
   logic          prev_ready = 1'b0;
   logic          prev_last = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          was_active, hs_now, done_next;
   int            cyc = 0;
   int            trig_cyc = 0;
   int            first_en_cyc = -1;
   int            first_valid_cyc = -1;
   int            last_beat_cyc = -1;
   int            frames_done_cnt = 0;
   int            frame_beats = 0;
   logic [DW-1:0] first_data = '0;
   logic [DW-1:0] last_data = '0;

   always @(negedge aclk) begin
      cyc++;
      if (!aresetn) begin
         chk("rst_ctrl", {59'd0, busy, frame_done, BRAM_EN, m_tvalid, m_tlast}, 64'd0);
         chk("rst_addr", 64'(BRAM_ADDR), 64'd0);
         chk("rst_tdata", 64'(m_tdata), 64'd0);
         m_active = 1'b0; m_done_exp = 1'b0; m_beat = 0; m_reads = 0; m_hs = 0;
         m_xor = '0; prev_valid = 1'b0; prev_ready = 1'b0;
      end else begin
         was_active = m_active;
         hs_now     = m_tvalid && m_tready;
         chk("busy", 64'(busy), 64'(m_active));
         chk("frame_done", 64'(frame_done), 64'(m_done_exp));
         chk("bram_we", 64'(BRAM_WE), 64'd0);
`ifdef MV_RESULT_CHECKSUM_EN
         chk("checksum_run", 64'(checksum), 64'(m_xor));
`endif
         if (frame_done) frames_done_cnt++;
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", 64'(m_tvalid), 64'd1);
            chk("hold_data", 64'(m_tdata), 64'(prev_data));
            chk("hold_last", 64'(m_tlast), 64'(prev_last));
         end
         if (m_tvalid) begin
            chk("valid_in_frame", 64'(m_active), 64'd1);
            chk("beat_range", 64'(m_beat < N), 64'd1);
            if (m_beat < N) chk("tdata", 64'(m_tdata), 64'(mem[m_beat]));
            chk("tlast", 64'(m_tlast), 64'(m_beat == N - 1));
         end
         if (BRAM_EN) begin
            chk("en_in_frame", 64'(m_active), 64'd1);
            chk("en_addr", 64'(BRAM_ADDR), 64'(BASE + 32'(4 * m_reads)));
            // words already issued but not yet consumed (this cycle's pop freed)
            chk("en_window", 64'((m_reads - m_hs - int'(hs_now)) < 2), 64'd1);
            if (first_en_cyc < 0) first_en_cyc = cyc;
            m_reads++;
         end
         done_next = 1'b0;
         if (hs_now) begin
            if (m_beat == 0) begin
               first_data      = m_tdata;
               first_valid_cyc = cyc;
            end
            m_xor ^= m_tdata;
            m_hs++;
            if (m_beat == N - 1) begin
               last_data     = m_tdata;
               last_beat_cyc = cyc;
               frame_beats   = m_beat + 1;
               m_active      = 1'b0;
               done_next     = 1'b1;
            end
            m_beat++;
         end
         m_done_exp = done_next;
         if (trig && !was_active) begin
            m_active = 1'b1; m_beat = 0; m_reads = 0; m_hs = 0; m_xor = '0;
            trig_cyc = cyc; first_en_cyc = -1; first_valid_cyc = -1;
         end
         prev_valid = m_tvalid;
         prev_ready = m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   function automatic logic ready_val(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 4 == 0) || (k % 4 == 3);
         2:       return 1'($urandom_range(0, 1));
         default: return ($urandom_range(0, 3) != 0);
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      tick(1);
      trig = 1'b0;
   endtask

   task automatic wait_frame(input int mode, input string name);
      int start;
      int k;
      start = frames_done_cnt;
      k = 0;
      while (frames_done_cnt == start && k < 3000) begin
         m_tready = ready_val(mode, k);
         tick(1);
         k++;
      end
      chk({name, "_completes"}, 64'(frames_done_cnt != start), 64'd1);
   endtask

   int fd0;
   int k0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) mem[i] = 32'(i + 100);
      aresetn = 1'b0;
      tick(3);
      aresetn = 1'b1;
      tick(2);

      // 1: full-rate frame, latency pins
      m_tready = 1'b1;
      fd0 = frames_done_cnt;
      pulse_trig();
      wait_frame(0, "t1");
      chk("t1_first_en_lat", 64'(first_en_cyc - trig_cyc), 64'd1);
      chk("t1_first_valid_lat", 64'(first_valid_cyc - trig_cyc), 64'd3);
      chk("t1_last_beat_lat", 64'(last_beat_cyc - trig_cyc), 64'(N + 2));
      chk("t1_first_data", 64'(first_data), 64'd100);
      chk("t1_last_data", 64'(last_data), 64'd163);
      chk("t1_beats", 64'(frame_beats), 64'd64);
      tick(2);
      chk("t1_busy_after", 64'(busy), 64'd0);
      chk("t1_one_done", 64'(frames_done_cnt - fd0), 64'd1);

      // 2: 1,0,0,1 ready pattern
      pulse_trig();
      wait_frame(1, "t2");
      chk("t2_beats", 64'(frame_beats), 64'd64);
      chk("t2_last_data", 64'(last_data), 64'd163);
      tick(2);

      // 3: stalled sink, only two reads may be outstanding
      m_tready = 1'b0;
      pulse_trig();
      tick(20);
      chk("t3_reads", 64'(m_reads), 64'd2);
      chk("t3_valid", 64'(m_tvalid), 64'd1);
      chk("t3_data", 64'(m_tdata), 64'd100);
      wait_frame(0, "t3");
      chk("t3_beats", 64'(frame_beats), 64'd64);
      tick(2);

      // 4: second trig while busy is ignored
      fd0 = frames_done_cnt;
      pulse_trig();
      k0 = 0;
      while (k0 < 10) begin
         m_tready = ready_val(2, k0);
         tick(1);
         k0++;
      end
      pulse_trig();
      wait_frame(2, "t4");
      m_tready = 1'b1;
      tick(30);
      chk("t4_single_done", 64'(frames_done_cnt - fd0), 64'd1);
      chk("t4_idle", 64'(busy), 64'd0);

      // 5: reset after beat 10 abandons the frame
      fd0 = frames_done_cnt;
      pulse_trig();
      k0 = 0;
      while (m_beat < 10 && k0 < 200) begin
         tick(1);
         k0++;
      end
      chk("t5_reached_beat10", 64'(m_beat >= 10), 64'd1);
      aresetn = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(m_tvalid), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_en", 64'(BRAM_EN), 64'd0);
      tick(3);
      aresetn = 1'b1;
      tick(3);
      chk("t5_no_done", 64'(frames_done_cnt - fd0), 64'd0);
      pulse_trig();
      wait_frame(3, "t5");
      chk("t5_first_data", 64'(first_data), 64'd100);
      chk("t5_beats", 64'(frame_beats), 64'd64);
      tick(2);

      // randomized data and backpressure
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) mem[i] = $urandom;
         pulse_trig();
         wait_frame(2 + (f % 2), "rnd");
         tick(int'($urandom_range(0, 3)));
      end

`ifdef MV_RESULT_CHECKSUM_EN
      // 6: checksum literals
      for (int i = 0; i < N; i++) mem[i] = 32'h1 << (i % 32);
      pulse_trig();
      wait_frame(3, "t6a");
      tick(3);
      chk("t6_walking_ones", 64'(checksum), 64'h0);
      for (int i = 0; i < N; i++) mem[i] = 32'h0;
      mem[0] = 32'hDEADBEEF;
      pulse_trig();
      wait_frame(2, "t6b");
      tick(3);
      chk("t6_deadbeef", 64'(checksum), 64'hDEADBEEF);
`endif

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
